// File: rtl/seq_borrow_lookahead_subtractor.sv
// Multi-cycle subtractor Diff = A - B - Bin. Each cycle resolves one CHUNK-bit slice with borrow lookahead.
// Optional macro SUB_SATURATE_EN clamps Diff_o to the signed extreme when overflow occurs.
module seq_borrow_lookahead_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Bin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] Diff_o,
  output logic             Bout_o,
  output logic             Ovf_o,
  output logic             busy_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // state | meaning
  // IDLE  | waiting for operands, ready_o high
  // CALC  | resolving slice cnt_q each cycle
  // DONE  | result held on outputs until downstream accepts
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, part_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK-1:0] sa, sb, g, p, d;
  logic [CHUNK:0]   bor;
  logic             last, accept, ovf_raw;
  logic             acc, t;
  logic [WIDTH-1:0] diff_raw, diff_fin;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign busy_o  = (state != IDLE);
  assign accept  = valid_i && ready_o;
  assign last    = (cnt_q == CW'(N - 1));

  // Slice borrows expanded from the registered slice borrow-in rather than rippled.
  always_comb begin
    sa  = a_q[cnt_q*CHUNK +: CHUNK];
    sb  = b_q[cnt_q*CHUNK +: CHUNK];
    g   = ~sa & sb;
    p   = ~(sa ^ sb);
    bor = '0;
    acc = 1'b0;
    t   = 1'b0;
    bor[0] = brw_q;
    for (int j = 0; j < CHUNK; j++) begin
      acc = g[j];
      t   = p[j];
      for (int k = j - 1; k >= 0; k--) begin
        acc = acc | (t & g[k]);
        t   = t & p[k];
      end
      bor[j+1] = acc | (t & brw_q);
    end
    d       = sa ^ sb ^ bor[CHUNK-1:0];
    ovf_raw = bor[CHUNK-1] ^ bor[CHUNK];
    diff_raw = part_q;
    diff_raw[cnt_q*CHUNK +: CHUNK] = d;
  end

`ifdef SUB_SATURATE_EN
  always_comb begin
    diff_fin = diff_raw;
    if (ovf_raw)
      diff_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    diff_fin = diff_raw;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      part_q <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      Diff_o <= '0;
      Bout_o <= 1'b0;
      Ovf_o  <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        a_q   <= A_i;
        b_q   <= B_i;
        brw_q <= Bin_i;
        cnt_q <= '0;
      end else if (state == CALC) begin
        part_q <= diff_raw;
        brw_q  <= bor[CHUNK];
        if (last) begin
          Diff_o <= diff_fin;
          Bout_o <= bor[CHUNK];
          Ovf_o  <= ovf_raw;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_borrow_lookahead_subtractor.sv
// Self-checking bench for seq_borrow_lookahead_subtractor: directed table, stall/reset sequences, random vs model.
// Honours SUB_SATURATE_EN for the expected saturated differences.
module tb_seq_borrow_lookahead_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, ready_i = 1'b0, bin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ready_o, valid_o, bout_o, ovf_o, busy_o;
  logic [15:0] diff_o;

  int vec_cnt = 0, err_cnt = 0;
  int acc_cnt = 0, hs_cnt = 0;

  seq_borrow_lookahead_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .A_i(a), .B_i(b), .Bin_i(bin), .valid_o(valid_o), .ready_i(ready_i),
    .Diff_o(diff_o), .Bout_o(bout_o), .Ovf_o(ovf_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && valid_i && ready_o) acc_cnt++;
    if (!rst && valid_o && ready_i) hs_cnt++;
  end

  typedef struct {
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] d;
    logic        bo, ov;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                                output logic [15:0] md, output logic mbo, output logic mov);
    int ur, sr;
    ur  = int'(ma) - int'(mb) - int'(mbin);
    sr  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    md  = ur[15:0];
    mbo = (ur < 0);
    mov = (sr > 32767) || (sr < -32768);
`ifdef SUB_SATURATE_EN
    if (mov) md = (sr < 0) ? 16'h8000 : 16'h7FFF;
`endif
  endfunction

  task automatic accept(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    int n = 0;
    while (!ready_o && n < 20) begin @(posedge clk); #1; n++; end
    if (!ready_o) chk("ready_timeout", {31'd0, ready_o}, 32'd1);
    a = ta; b = tb_; bin = tbin; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!valid_o) chk("valid_timeout", {31'd0, valid_o}, 32'd1);
  endtask

  task automatic drain(input int stall, output logic [15:0] d, output logic bo, output logic ov);
    d = diff_o; bo = bout_o; ov = ovf_o;
    ready_i = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    if (stall > 0) chk("hold_stable", {15'd0, diff_o, bout_o}, {15'd0, d, bo});
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin : main
    logic [15:0] d, md;
    logic        bo, ov, mbo, mov;
    int          lat;

    tv[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    tv[1] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
    tv[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
`ifdef SUB_SATURATE_EN
    tv[3] = '{16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
`else
    tv[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tv[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
`endif
    tv[5] = '{16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tv[6] = '{16'hC3C3, 16'hC3C3, 1'b0, 16'h0000, 1'b0, 1'b0};
    tv[7] = '{16'h0FFF, 16'h1000, 1'b1, 16'hFFFE, 1'b1, 1'b0};

    #3;
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_outs", {12'd0, diff_o, valid_o, busy_o, bout_o, ovf_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      accept(tv[i].a, tv[i].b, tv[i].bin);
      wait_valid(lat);
      chk($sformatf("latency_%0d", i), lat, 32'd4);
      drain(i % 3, d, bo, ov);
      chk($sformatf("diff_%0d", i), {16'd0, d}, {16'd0, tv[i].d});
      chk($sformatf("flags_%0d", i), {30'd0, bo, ov}, {30'd0, tv[i].bo, tv[i].ov});
      chk($sformatf("idle_after_%0d", i), {30'd0, ready_o, valid_o}, 32'd2);
    end

    // DONE stall with new operands presented: no acceptance until after return to IDLE.
    accept(16'h0100, 16'h0001, 1'b0);
    wait_valid(lat);
    a = 16'h2000; b = 16'h0FFF; bin = 1'b1; valid_i = 1'b1; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_diff", {16'd0, diff_o}, 32'h00FF);
      chk("stall_hs", {30'd0, valid_o, ready_o}, 32'd2);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("stall_idle", {30'd0, valid_o, ready_o}, 32'd1);
    chk("idle_keeps", {16'd0, diff_o}, 32'h00FF);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("stall_accepted", {30'd0, busy_o, ready_o}, 32'd2);
    wait_valid(lat);
    chk("stall_next_lat", lat, 32'd4);
    drain(0, d, bo, ov);
    chk("stall_next_diff", {15'd0, d, bo}, {15'd0, 16'h1000, 1'b0});

    // Asynchronous reset during the second CALC cycle.
    accept(16'h1111, 16'h0001, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_outs", {12'd0, diff_o, valid_o, busy_o, bout_o, ovf_o}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_valid", {31'd0, valid_o}, 32'd0);
    end
    rst = 1'b0;
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    wait_valid(lat);
    drain(1, d, bo, ov);
    chk("post_rst", {14'd0, d, bo, ov}, {14'd0, 16'hFFFF, 1'b1, 1'b0});

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      model(ra, rb, rbin, md, mbo, mov);
      accept(ra, rb, rbin);
      wait_valid(lat);
      drain(int'($urandom_range(0, 3)), d, bo, ov);
      chk("rand_result", {14'd0, d, bo, ov}, {14'd0, md, mbo, mov});
    end

    @(posedge clk); #1;
    chk("handshakes", hs_cnt + 1, acc_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
